// File: rtl/pip_pkg.sv
// Shared definitions for the MIPS pipeline front end: PCSrc encodings,
// the NOP encoding and the fetch FSM state type.
package pip_pkg;
  localparam logic [1:0]  PC_SEQ = 2'b00;
  localparam logic [1:0]  PC_BR  = 2'b01;
  localparam logic [1:0]  PC_J   = 2'b10;
  localparam logic [1:0]  PC_JR  = 2'b11;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} fstate_e;
endpackage

// File: rtl/npc_calc.sv
// Redirect-target mux: branch, jump or register-jump target from the
// instruction held in IF/ID.
module npc_calc
  import pip_pkg::*;
(
  input  logic [1:0]  pcsrc_i,
  input  logic [25:0] instr_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] jr_addr_i,
  output logic [31:0] target_o
);
  logic [31:0] br_off;

  assign br_off = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};

  always_comb begin
    target_o = pc4_i;
    case (pcsrc_i)
      PC_BR:   target_o = pc4_i + br_off;
      PC_J:    target_o = {pc4_i[31:28], instr_i, 2'b00};
      PC_JR:   target_o = jr_addr_i;
      default: target_o = pc4_i;
    endcase
  end
endmodule

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register with req/ack imem handshake and a
// one-word skid buffer. Define IF_PERF_CNT_EN to add stall/flush counters.
module if_stage
  import pip_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  fstate_e     state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_q, skid_d;
  logic        discard_q, discard_d;
  logic [31:0] saved_q, saved_d;

  logic [31:0] pc_plus4, target;
  logic        redirect;

  assign pc_plus4 = pc_q + 32'd4;
  assign redirect = valid_q & ~stall & (PCSrc != PC_SEQ);

  npc_calc u_npc (
    .pcsrc_i   (PCSrc),
    .instr_i   (instr_q[25:0]),
    .pc4_i     (pc4_q),
    .jr_addr_i (jr_addr),
    .target_o  (target)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    valid_d   = valid_q;
    skid_d    = skid_q;
    discard_d = discard_q;
    saved_d   = saved_q;
    case (state_q)
      FETCH: begin
        if (stall) begin
          // A stale word still retires the squashed request during a stall.
          if (imem_ack) begin
            if (discard_q) begin
              pc_d      = saved_q;
              discard_d = 1'b0;
            end else begin
              skid_d  = imem_rdata;
              state_d = HOLD;
            end
          end
        end else if (redirect) begin
          valid_d = 1'b0;
          if (imem_ack) begin
            pc_d      = target;
            discard_d = 1'b0;
          end else begin
            // Address must stay stable until the pending fetch completes.
            saved_d   = target;
            discard_d = 1'b1;
          end
        end else if (imem_ack) begin
          if (discard_q) begin
            pc_d      = saved_q;
            discard_d = 1'b0;
            valid_d   = 1'b0;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          valid_d = 1'b0;
        end
      end
      HOLD: begin
        if (!stall) begin
          state_d = FETCH;
          if (redirect) begin
            valid_d = 1'b0;
            pc_d    = target;
          end else begin
            instr_d = skid_q;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc4_q     <= 32'h0;
      valid_q   <= 1'b0;
      skid_q    <= NOP_INSTR;
      discard_q <= 1'b0;
      saved_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      valid_q   <= valid_d;
      skid_q    <= skid_d;
      discard_q <= discard_d;
      saved_q   <= saved_d;
    end
  end

  assign imem_req   = (state_q == FETCH);
  assign imem_addr  = pc_q;
  assign ifid_instr = instr_q;
  assign ifid_pc4   = pc4_q;
  assign ifid_valid = valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: sequential fetch, branch/jump/jr redirects,
// stall with skid, late-ack discard, PC wrap and reset during a pending fetch.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, stall;
  logic [1:0]  PCSrc;
  logic [31:0] jr_addr;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  logic        ack_en, ovr_en;
  logic [31:0] ovr;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  // Memory model: zero-wait when enabled, word = address-tagged pattern
  assign imem_ack   = ack_en & imem_req;
  assign imem_rdata = ovr_en ? ovr : (32'hA500_0000 ^ imem_addr);

  if_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .jr_addr    (jr_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PCSrc = 2'b00; jr_addr = 32'h0;
    ack_en = 1'b0; ovr_en = 1'b0; ovr = 32'h0;
    step(); step();
    chk("rst_req",   {31'h0, imem_req}, 32'h1);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'h0, ifid_valid}, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4",   ifid_pc4, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("rst_scnt", stall_cnt, 32'h0);
    chk("rst_fcnt", flush_cnt, 32'h0);
`endif

    // Zero-wait sequential fetch
    rst = 1'b0; ack_en = 1'b1;
    chk("seq_addr0", imem_addr, 32'h0);
    step();
    chk("seq_addr1", imem_addr, 32'h4);
    chk("seq_pc4_1", ifid_pc4, 32'h4);
    chk("seq_val1",  {31'h0, ifid_valid}, 32'h1);
    chk("seq_ins1",  ifid_instr, 32'hA500_0000);
    step();
    chk("seq_addr2", imem_addr, 32'h8);
    chk("seq_pc4_2", ifid_pc4, 32'h8);
    step();
    chk("seq_pc4_3", ifid_pc4, 32'hC);
    chk("seq_ins3",  ifid_instr, 32'hA500_0008);

    // beq -2 at pc4=0x10 -> target 0x08, word from 0x10 squashed
    ovr_en = 1'b1; ovr = 32'h1000_FFFE;
    step();
    chk("br_pc4", ifid_pc4, 32'h10);
    chk("br_ins", ifid_instr, 32'h1000_FFFE);
    ovr_en = 1'b0; PCSrc = 2'b01;
    step();
    chk("br_addr",  imem_addr, 32'h8);
    chk("br_squash", {31'h0, ifid_valid}, 32'h0);
    PCSrc = 2'b00;
    step();
    chk("br_ins2", ifid_instr, 32'hA500_0008);
    chk("br_pc4_2", ifid_pc4, 32'hC);
    chk("br_val2", {31'h0, ifid_valid}, 32'h1);

    // Stall 3 cycles while ack arrives -> skid, HOLD
    stall = 1'b1;
    step();
    chk("st_req0", {31'h0, imem_req}, 32'h0);
    chk("st_pc4_0", ifid_pc4, 32'hC);
    step(); step();
    chk("st_req2", {31'h0, imem_req}, 32'h0);
    chk("st_pc4_2", ifid_pc4, 32'hC);
    chk("st_ins2", ifid_instr, 32'hA500_0008);
    stall = 1'b0;
    step();
    chk("st_rel_ins", ifid_instr, 32'hA500_000C);
    chk("st_rel_pc4", ifid_pc4, 32'h10);
    chk("st_rel_addr", imem_addr, 32'h10);
    chk("st_rel_req", {31'h0, imem_req}, 32'h1);

    // jr to 0x400 while the fetch at 0x10 is pending; ack 3 cycles late
    ack_en = 1'b0; PCSrc = 2'b11; jr_addr = 32'h400;
    step();
    chk("jr_hold_addr", imem_addr, 32'h10);
    chk("jr_val", {31'h0, ifid_valid}, 32'h0);
    PCSrc = 2'b00;
    step(); step();
    chk("jr_wait_addr", imem_addr, 32'h10);
    ack_en = 1'b1;
    step();
    chk("jr_addr", imem_addr, 32'h400);
    chk("jr_drop", {31'h0, ifid_valid}, 32'h0);
    step();
    chk("jr_pc4", ifid_pc4, 32'h404);
    chk("jr_ins", ifid_instr, 32'hA500_0400);

    // Jump with upper nibble F: first jr to 0xF000_000C
    PCSrc = 2'b11; jr_addr = 32'hF000_000C;
    step();
    chk("j_pre_addr", imem_addr, 32'hF000_000C);
    PCSrc = 2'b00; ovr_en = 1'b1; ovr = 32'h0800_0100;
    step();
    chk("j_pc4", ifid_pc4, 32'hF000_0010);
    ovr_en = 1'b0; PCSrc = 2'b10;
    step();
    chk("j_addr", imem_addr, 32'hF000_0400);
    PCSrc = 2'b00;
    step();

    // PC+4 wrap
    PCSrc = 2'b11; jr_addr = 32'hFFFF_FFFC;
    step();
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    PCSrc = 2'b00;
    step();
    chk("wr_pc4", ifid_pc4, 32'h0);
    chk("wr_ins", ifid_instr, 32'h5AFF_FFFC);
    chk("wr_addr2", imem_addr, 32'h0);
`ifdef IF_PERF_CNT_EN
    chk("scnt", stall_cnt, 32'd3);
    chk("fcnt", flush_cnt, 32'd5);
`endif

    // Reset during a pending fetch with a late ack
    ack_en = 1'b0;
    step();
    rst = 1'b1; ack_en = 1'b1;
    step();
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_val", {31'h0, ifid_valid}, 32'h0);
    chk("mr_ins", ifid_instr, 32'h0);
    chk("mr_req", {31'h0, imem_req}, 32'h1);
`ifdef IF_PERF_CNT_EN
    chk("mr_scnt", stall_cnt, 32'h0);
    chk("mr_fcnt", flush_cnt, 32'h0);
`endif
    rst = 1'b0;
    step();
    chk("mr_pc4", ifid_pc4, 32'h4);
    chk("mr_val2", {31'h0, ifid_valid}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register of the pipelined MIPS core. Owns the PC and fetches from instruction memory over a req/ack handshake. Presents the registered instruction and PC+4 to decode, whose control unit slices Opcode/func/Rt from it. Consumes decode's PCSrc redirect and the hazard unit's stall.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard unit: hold PC and IF/ID
PCSrc  in  2  from control unit: 00 PC+4, 01 branch, 10 j/jal, 11 jr/jalr
jr_addr  in  32  forwarded Rs value for jr/jalr
imem_req  out  1  fetch request
imem_addr  out  32  fetch address; word aligned
imem_rdata  in  32  instruction word; valid when imem_ack=1
imem_ack  in  1  fetch complete; may assert in the same cycle as imem_req
ifid_instr  out  32  registered instruction
ifid_pc4  out  32  registered PC+4 of ifid_instr
ifid_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset: pc=RESET_PC, state=FETCH, ifid_instr=32'h0 (NOP), ifid_pc4=0, ifid_valid=0, skid empty, discard=0. imem_req is 1 in the first cycle after reset.
- Redirect: redirect = ifid_valid & !stall & PCSrc!=00.
- Redirect targets:
  - 01: ifid_pc4 + (sext(ifid_instr[15:0])<<2), modulo 2^32.
  - 10: {ifid_pc4[31:28], ifid_instr[25:0], 2'b00}.
  - 11: jr_addr.
- No delay slot. A redirect squashes the instruction currently in IF.
- imem_addr = pc. It stays stable while a request is pending.
- State FETCH (imem_req=1):
  - ack & !stall & !redirect & !discard: ifid <= {rdata, pc+4, 1}; pc <= pc+4.
  - ack & stall: rdata -> skid buffer; state <= HOLD; ifid unchanged.
  - ack & redirect: rdata dropped; ifid_valid <= 0; pc <= target.
  - ack & discard: rdata dropped; pc <= saved target; discard <= 0.
  - !ack & redirect: save target; discard <= 1; ifid_valid <= 0; pc unchanged until ack.
  - !ack & stall: ifid held.
  - !ack, otherwise: ifid_valid <= 0 (bubble).
- State HOLD (imem_req=0):
  - stall: hold everything.
  - !stall & !redirect: ifid <= {skid, pc+4, 1}; pc <= pc+4; state <= FETCH.
  - !stall & redirect: skid dropped; ifid_valid <= 0; pc <= target; state <= FETCH.
- Priority: rst > stall > redirect > sequential advance. Redirect is never evaluated while stall=1.
- Back-to-back zero-wait acks sustain one instruction per cycle.
- A second redirect while discard=1 overwrites the saved target.
- rst during a pending request: the request is abandoned. A late ack in the first cycle after reset is ignored (discard state cleared, pc=RESET_PC).
- PC+4 wraps 32'hFFFF_FFFC -> 0.

Optional Feature:
IF_PERF_CNT_EN
- Defined: adds output ports stall_cnt[31:0] and flush_cnt[31:0].
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments on each redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Decomposition:
- Package pip_pkg:
  - PCSrc encodings (PC_SEQ=2'b00, PC_BR=2'b01, PC_J=2'b10, PC_JR=2'b11).
  - NOP_INSTR=32'h0.
  - Fetch state enum {FETCH, HOLD}.
- Sub-module npc_calc: combinational redirect-target mux from PCSrc, ifid_instr, ifid_pc4, jr_addr.

Test Plan:
- Reset then zero-wait acks: imem_addr 0, 4, 8 on consecutive cycles; ifid_pc4 = 4, 8, 12 with ifid_valid=1 from cycle 2.
- ifid_instr = beq (imm 16'hFFFE) at pc4=0x10 with PCSrc=01 -> next imem_addr = 0x08; the instruction fetched from 0x10 never reaches IF/ID (ifid_valid=0 one cycle).
- stall=1 for 3 cycles while ack arrives -> ifid constant, imem_req=0 in HOLD; on release, the skid word enters IF/ID and imem_addr advances by 4.
- ack delayed 3 cycles, jr with jr_addr=0x400 issued during the wait -> the late word is dropped and the next request addr = 0x400.
- Jump from ifid_pc4=0xF000_0010 with instr[25:0]=0x100 -> imem_addr = 0xF000_0400.
- rst asserted mid-pending fetch with a late ack -> pc=RESET_PC, ifid_valid=0; with IF_PERF_CNT_EN defined, stall_cnt and flush_cnt are 0.
